// File: rtl/hilo_mult_div_if.sv
// rtl/hilo_mult_div_if.sv - request/result bundle between EX stage and the HI/LO multiply/divide unit
interface hilo_mult_div_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            busy;
  logic [XLEN-1:0] out_MulDiv_Hi;
  logic [XLEN-1:0] out_MulDiv_Lo;
  logic            out_MulDiv_Write_HiLo_Ctrl;

  modport master (
    output start, op, operand_a, operand_b,
    input  busy, out_MulDiv_Hi, out_MulDiv_Lo, out_MulDiv_Write_HiLo_Ctrl
  );

  modport slave (
    input  start, op, operand_a, operand_b,
    output busy, out_MulDiv_Hi, out_MulDiv_Lo, out_MulDiv_Write_HiLo_Ctrl
  );
endinterface

// File: rtl/hilo_mult_div.sv
// rtl/hilo_mult_div.sv - iterative 32-cycle shift-add multiplier / restoring divider driving the HI/LO write port
module hilo_mult_div #(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  hilo_mult_div_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_SIGN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic              dbz_q, dbz_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   raw_a_q, raw_a_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic              busy_q, busy_d;
  logic              strobe_q, strobe_d;

  logic              in_signed, res_signed;
  logic [XLEN-1:0]   a_abs, b_abs;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  assign in_signed  = ~bus.op[0];
  assign res_signed = ~op_q[0];
  assign a_abs = (in_signed && bus.operand_a[XLEN-1]) ? -bus.operand_a : bus.operand_a;
  assign b_abs = (in_signed && bus.operand_b[XLEN-1]) ? -bus.operand_b : bus.operand_b;

  // acc[63:32] is the running partial product / remainder; the 33rd sum bit is the carry shifted back in
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (b_q[0] ? a_q : {XLEN{1'b0}})};
  assign rem_sh   = {acc_q[2*XLEN-1:XLEN], a_q[XLEN-1]};
  assign div_diff = rem_sh - {1'b0, b_q};

  assign prod_fix = (res_signed && neg_res_q) ? -acc_q : acc_q;
  assign quo_fix  = (res_signed && neg_res_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_fix  = (res_signed && neg_rem_q) ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;
    a_d       = a_q;
    b_d       = b_q;
    raw_a_d   = raw_a_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    strobe_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d      = bus.op;
          neg_res_d = bus.operand_a[XLEN-1] ^ bus.operand_b[XLEN-1];
          neg_rem_d = bus.operand_a[XLEN-1];
          dbz_d     = (bus.operand_b == '0);
          a_d       = a_abs;
          b_d       = b_abs;
          raw_a_d   = bus.operand_a;
          acc_d     = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = S_CALC;
        end
      end
      S_CALC: begin
        if (op_q[1]) begin
          a_d = a_q << 1;
          if (!div_diff[XLEN]) acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
          else                 acc_d = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
          b_d   = b_q >> 1;
          acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(XLEN-1)) begin
          cnt_d   = '0;
          state_d = S_SIGN;
        end
      end
      S_SIGN: begin
        // Results are registered on the way into DONE so they are valid alongside the strobe
        if (!op_q[1]) begin
          hi_d = prod_fix[2*XLEN-1:XLEN];
          lo_d = prod_fix[XLEN-1:0];
        end else if (dbz_q) begin
          hi_d = raw_a_q;
          lo_d = {XLEN{1'b1}};
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        strobe_d = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      raw_a_q   <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
      a_q       <= a_d;
      b_q       <= b_d;
      raw_a_q   <= raw_a_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      strobe_q  <= strobe_d;
    end
  end

  assign bus.busy                       = busy_q;
  assign bus.out_MulDiv_Hi              = hi_q;
  assign bus.out_MulDiv_Lo              = lo_q;
  assign bus.out_MulDiv_Write_HiLo_Ctrl = strobe_q;

endmodule

// File: tb/tb_hilo_mult_div.sv
// tb/tb_hilo_mult_div.sv - directed self-checking bench for hilo_mult_div
module tb_hilo_mult_div;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hilo_mult_div_if #(.XLEN(32)) bus ();

  hilo_mult_div #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  int          strb_cnt, strb_at;
  logic [31:0] got_hi, got_lo, mid_hi, mid_lo;
  logic        busy_k1, busy_k34, busy_k35;
  logic        r_busy, r_strb;
  logic [31:0] r_hi, r_lo;

  // Drives one request (accepted at the next rising edge k) and records what is seen in cycles k+1..k+ncyc
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int ncyc, input int intf_at, input int rst_at);
    bus.start = 1'b1;
    bus.op = op;
    bus.operand_a = a;
    bus.operand_b = b;
    strb_cnt = 0;
    strb_at = -1;
    got_hi = 'x; got_lo = 'x; mid_hi = 'x; mid_lo = 'x;
    busy_k1 = 1'bx; busy_k34 = 1'bx; busy_k35 = 1'bx;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.operand_a = 32'hDEADBEEF;
    bus.operand_b = 32'h12345678;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      if (n == intf_at) begin
        bus.start = 1'b1;
        bus.op = 2'b01;
        bus.operand_a = 32'd5;
        bus.operand_b = 32'd5;
      end else if (n == intf_at + 1) begin
        bus.start = 1'b0;
      end
      if (n == rst_at) begin
        rst_n = 1'b0;
        #1;
        r_busy = bus.busy;
        r_strb = bus.out_MulDiv_Write_HiLo_Ctrl;
        r_hi = bus.out_MulDiv_Hi;
        r_lo = bus.out_MulDiv_Lo;
      end else if (n == rst_at + 1) begin
        rst_n = 1'b1;
      end
      if (bus.out_MulDiv_Write_HiLo_Ctrl === 1'b1) begin
        strb_cnt++;
        if (strb_at < 0) begin
          strb_at = n;
          got_hi = bus.out_MulDiv_Hi;
          got_lo = bus.out_MulDiv_Lo;
        end
      end
      if (n == 1)  busy_k1  = bus.busy;
      if (n == 20) begin mid_hi = bus.out_MulDiv_Hi; mid_lo = bus.out_MulDiv_Lo; end
      if (n == 34) busy_k34 = bus.busy;
      if (n == 35) busy_k35 = bus.busy;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.operand_a = '0;
    bus.operand_b = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.out_MulDiv_Write_HiLo_Ctrl !== 1'b0) begin errors++; $display("FAIL reset_strobe got %b exp 0", bus.out_MulDiv_Write_HiLo_Ctrl); end
    checks++; if (bus.out_MulDiv_Hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h exp 0", bus.out_MulDiv_Hi); end
    checks++; if (bus.out_MulDiv_Lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h exp 0", bus.out_MulDiv_Lo); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult();
    do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 35, -5, -5);
    checks++; if (strb_at !== 34) begin errors++; $display("FAIL multu_strobe_cycle got %0d exp 34", strb_at); end
    checks++; if (strb_cnt !== 1) begin errors++; $display("FAIL multu_strobe_count got %0d exp 1", strb_cnt); end
    checks++; if (got_hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi got %h exp fffffffe", got_hi); end
    checks++; if (got_lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo got %h exp 00000001", got_lo); end
    checks++; if (busy_k1 !== 1'b1) begin errors++; $display("FAIL multu_busy_k1 got %b exp 1", busy_k1); end
    checks++; if (busy_k34 !== 1'b1) begin errors++; $display("FAIL multu_busy_k34 got %b exp 1", busy_k34); end
    checks++; if (busy_k35 !== 1'b0) begin errors++; $display("FAIL multu_busy_k35 got %b exp 0", busy_k35); end

    do_op(2'b00, 32'hFFFFFFFD, 32'd7, 35, -5, -5);
    checks++; if (mid_hi !== 32'hFFFFFFFE || mid_lo !== 32'h00000001) begin errors++; $display("FAIL mult_hold_mid got %h_%h exp fffffffe_00000001", mid_hi, mid_lo); end
    checks++; if (got_hi !== 32'hFFFFFFFF || got_lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_neg got %h_%h exp ffffffff_ffffffeb", got_hi, got_lo); end

    do_op(2'b00, 32'h80000000, 32'h80000000, 35, -5, -5);
    checks++; if (got_hi !== 32'h40000000 || got_lo !== 32'h0) begin errors++; $display("FAIL mult_minsq got %h_%h exp 40000000_00000000", got_hi, got_lo); end
  endtask

  task automatic test_div();
    do_op(2'b10, 32'hFFFFFFF9, 32'd2, 35, -5, -5);
    checks++; if (got_lo !== 32'hFFFFFFFD || got_hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_neg got lo %h hi %h exp lo fffffffd hi ffffffff", got_lo, got_hi); end
    checks++; if (strb_at !== 34) begin errors++; $display("FAIL div_strobe_cycle got %0d exp 34", strb_at); end

    do_op(2'b11, 32'd7, 32'd2, 35, -5, -5);
    checks++; if (got_lo !== 32'd3 || got_hi !== 32'd1) begin errors++; $display("FAIL divu got lo %h hi %h exp lo 3 hi 1", got_lo, got_hi); end

    do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 35, -5, -5);
    checks++; if (got_lo !== 32'h80000000 || got_hi !== 32'h0) begin errors++; $display("FAIL div_ovf got lo %h hi %h exp lo 80000000 hi 0", got_lo, got_hi); end

    do_op(2'b11, 32'hFFFFFFFF, 32'h10000, 35, -5, -5);
    checks++; if (got_lo !== 32'h0000FFFF || got_hi !== 32'h0000FFFF) begin errors++; $display("FAIL divu_big got lo %h hi %h exp lo 0000ffff hi 0000ffff", got_lo, got_hi); end
  endtask

  task automatic test_div_by_zero();
    do_op(2'b11, 32'd7, 32'd0, 35, -5, -5);
    checks++; if (got_lo !== 32'hFFFFFFFF || got_hi !== 32'd7) begin errors++; $display("FAIL divu_zero got lo %h hi %h exp lo ffffffff hi 7", got_lo, got_hi); end
    checks++; if (strb_at !== 34) begin errors++; $display("FAIL divu_zero_cycle got %0d exp 34", strb_at); end

    do_op(2'b10, 32'hFFFFFFFB, 32'd0, 35, -5, -5);
    checks++; if (got_lo !== 32'hFFFFFFFF || got_hi !== 32'hFFFFFFFB) begin errors++; $display("FAIL div_zero got lo %h hi %h exp lo ffffffff hi fffffffb", got_lo, got_hi); end
    checks++; if (strb_at !== 34) begin errors++; $display("FAIL div_zero_cycle got %0d exp 34", strb_at); end
  endtask

  task automatic test_ignore_busy();
    do_op(2'b11, 32'd7, 32'd2, 45, 10, -5);
    checks++; if (strb_cnt !== 1) begin errors++; $display("FAIL ignore_strobe_count got %0d exp 1", strb_cnt); end
    checks++; if (strb_at !== 34) begin errors++; $display("FAIL ignore_strobe_cycle got %0d exp 34", strb_at); end
    checks++; if (got_lo !== 32'd3 || got_hi !== 32'd1) begin errors++; $display("FAIL ignore_result got lo %h hi %h exp lo 3 hi 1", got_lo, got_hi); end
    checks++; if (busy_k35 !== 1'b0) begin errors++; $display("FAIL ignore_busy_k35 got %b exp 0", busy_k35); end
  endtask

  task automatic test_reset_midflight();
    do_op(2'b01, 32'd6, 32'd7, 40, -5, 20);
    checks++; if (r_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", r_busy); end
    checks++; if (r_strb !== 1'b0) begin errors++; $display("FAIL rst_strobe got %b exp 0", r_strb); end
    checks++; if (r_hi !== 32'h0 || r_lo !== 32'h0) begin errors++; $display("FAIL rst_outputs got %h_%h exp 0_0", r_hi, r_lo); end
    checks++; if (strb_cnt !== 0) begin errors++; $display("FAIL rst_no_strobe got %0d exp 0", strb_cnt); end

    do_op(2'b11, 32'd100, 32'd7, 35, -5, -5);
    checks++; if (strb_at !== 34) begin errors++; $display("FAIL post_rst_cycle got %0d exp 34", strb_at); end
    checks++; if (got_lo !== 32'd14 || got_hi !== 32'd2) begin errors++; $display("FAIL post_rst_result got lo %h hi %h exp lo e hi 2", got_lo, got_hi); end
  endtask

  task automatic test_back_to_back();
    do_op(2'b11, 32'd7, 32'd2, 35, -5, -5);
    checks++; if (got_lo !== 32'd3 || got_hi !== 32'd1) begin errors++; $display("FAIL b2b_first got lo %h hi %h exp lo 3 hi 1", got_lo, got_hi); end
    do_op(2'b01, 32'd3, 32'd5, 35, -5, -5);
    checks++; if (busy_k1 !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy %b exp 1", busy_k1); end
    checks++; if (strb_at !== 34) begin errors++; $display("FAIL b2b_cycle got %0d exp 34", strb_at); end
    checks++; if (got_lo !== 32'd15 || got_hi !== 32'd0) begin errors++; $display("FAIL b2b_second got lo %h hi %h exp lo f hi 0", got_lo, got_hi); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_by_zero();
    test_ignore_busy();
    test_reset_midflight();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
